// File: rtl/mdu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mdu_pkg
// Description : Shared multiply/divide unit definitions: M-extension multiply
//               op encoding, request-sequencer state encoding and the
//               op-to-unsigned-mode decode used to drive the multiplier.
// Revision    : 1.0 - initial release
// ============================================================================
package mdu_pkg;

  typedef enum logic [1:0] {
    OP_MUL    = 2'b00,
    OP_MULH   = 2'b01,
    OP_MULHSU = 2'b10,
    OP_MULHU  = 2'b11
  } mdu_op_t;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LAUNCH = 3'd1,
    ST_WAIT   = 3'd2,
    ST_RESP   = 3'd3,
    ST_HUNG   = 3'd4
  } mul_issue_state_t;

  // Only MULH needs a true signed x signed product. MUL takes the low half,
  // which is sign-agnostic, and MULHSU is corrected afterwards from an
  // unsigned product.
  function automatic logic op_usigned(input mdu_op_t op);
    return (op != OP_MULH);
  endfunction

endpackage
`default_nettype wire

// File: rtl/mul_issue_seq_if.sv
`default_nettype none
// ============================================================================
// Module      : mul_issue_seq_if
// Description : Bundle of the request, response and multiplier-side signals
//               of mul_issue_seq.
//               slave  : the sequencer's view.
//               master : the environment's view (request source, response
//                        sink and multiplier).
//               Signals: in_valid/in_ready/in_op/in_rs1/in_rs2/in_tag, flush,
//                        out_valid/out_ready/out_result/out_tag/out_err,
//                        mul_valid/mul_usigned/mul_multiplicand/
//                        mul_multiplier/mul_product/mul_res_ready.
// Revision    : 1.0 - initial release
// ============================================================================
interface mul_issue_seq_if #(
  parameter int W     = 32,
  parameter int TAG_W = 5
);
  import mdu_pkg::*;

  logic               in_valid;
  logic               in_ready;
  mdu_op_t            in_op;
  logic [W-1:0]       in_rs1;
  logic [W-1:0]       in_rs2;
  logic [TAG_W-1:0]   in_tag;
  logic               flush;

  logic               out_valid;
  logic               out_ready;
  logic [W-1:0]       out_result;
  logic [TAG_W-1:0]   out_tag;
  logic               out_err;

  logic               mul_valid;
  logic               mul_usigned;
  logic [W-1:0]       mul_multiplicand;
  logic [W-1:0]       mul_multiplier;
  logic [2*W-1:0]     mul_product;
  logic               mul_res_ready;

  modport slave (
    input  in_valid, in_op, in_rs1, in_rs2, in_tag, flush,
    output in_ready,
    input  out_ready,
    output out_valid, out_result, out_tag, out_err,
    output mul_valid, mul_usigned, mul_multiplicand, mul_multiplier,
    input  mul_product, mul_res_ready
  );

  modport master (
    output in_valid, in_op, in_rs1, in_rs2, in_tag, flush,
    input  in_ready,
    output out_ready,
    input  out_valid, out_result, out_tag, out_err,
    input  mul_valid, mul_usigned, mul_multiplicand, mul_multiplier,
    output mul_product, mul_res_ready
  );

endinterface
`default_nettype wire

// File: rtl/mul_issue_seq.sv
`default_nettype none
// ============================================================================
// Module      : mul_issue_seq
// Description : Request sequencer in front of the iterative multiplier.
//               Accepts one MUL/MULH/MULHSU/MULHU request at a time, pulses
//               the multiplier start for one cycle with registered operands,
//               waits for done (with a watchdog), selects and sign-corrects
//               the result half and returns it with its tag.
//               Ports : clk, rst_n (synchronous, active-low),
//                       bus (mul_issue_seq_if.slave).
//               Params: W (operand width), TAG_W (tag width),
//                       MAX_WAIT (watchdog limit in WAIT cycles).
//               Macro : MUL_ISSUE_MULHSU_EN - execute MULHSU; when undefined
//                       MULHSU is answered immediately with out_err=1.
// Revision    : 1.0 - initial release
// ============================================================================
module mul_issue_seq
  import mdu_pkg::*;
#(
  parameter int W        = 32,
  parameter int TAG_W    = 5,
  parameter int MAX_WAIT = 127
) (
  input  logic               clk,
  input  logic               rst_n,
  mul_issue_seq_if.slave     bus
);

  localparam int c_cnt_w = $clog2(MAX_WAIT + 1);
  // The counter holds the number of WAIT cycles already completed, so the
  // MAX_WAIT-th WAIT cycle is the one where it reads MAX_WAIT-1.
  localparam logic [c_cnt_w-1:0] c_wait_last = c_cnt_w'(MAX_WAIT - 1);

  mul_issue_state_t   r_state;
  mul_issue_state_t   w_next;
  mdu_op_t            r_op;
  logic [W-1:0]       r_rs1;
  logic [W-1:0]       r_rs2;
  logic [TAG_W-1:0]   r_tag;
  logic               r_usigned;
  logic [c_cnt_w-1:0] r_cnt;
  logic               r_discard;
  logic               r_hang;
  logic [W-1:0]       r_result;
  logic               r_err;

  logic               w_idle;
  logic               w_accept;
  logic               w_illegal;
  logic               w_timeout;
  logic [W-1:0]       w_hi;
  logic [W-1:0]       w_sel;

  assign w_idle    = (r_state == ST_IDLE);
  assign w_accept  = w_idle & bus.in_valid & ~bus.flush;
  assign w_timeout = (r_state == ST_WAIT) & ~bus.mul_res_ready &
                     (r_cnt == c_wait_last);

`ifdef MUL_ISSUE_MULHSU_EN
  assign w_illegal = 1'b0;
`else
  assign w_illegal = (bus.in_op == OP_MULHSU);
`endif

  assign bus.in_ready         = w_idle & ~bus.flush;
  assign bus.mul_valid        = (r_state == ST_LAUNCH);
  assign bus.mul_usigned      = r_usigned;
  assign bus.mul_multiplicand = r_rs1;
  assign bus.mul_multiplier   = r_rs2;
  assign bus.out_valid        = (r_state == ST_RESP);
  assign bus.out_result       = r_result;
  assign bus.out_tag          = r_tag;
  assign bus.out_err          = r_err;

  // Result half selection; MULHSU is run as unsigned x unsigned and the
  // high half is fixed up by subtracting rs2 when rs1 is negative.
  always_comb begin
    w_hi  = bus.mul_product[2*W-1:W];
    w_sel = w_hi;
    case (r_op)
      OP_MUL:    w_sel = bus.mul_product[W-1:0];
`ifdef MUL_ISSUE_MULHSU_EN
      OP_MULHSU: w_sel = w_hi - (r_rs1[W-1] ? r_rs2 : '0);
`endif
      default:   w_sel = w_hi;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_next = w_illegal ? ST_RESP : ST_LAUNCH;
        end
      end
      ST_LAUNCH: begin
        w_next = ST_WAIT;
      end
      ST_WAIT: begin
        // A flush in the done cycle itself is treated like an earlier one.
        if (bus.mul_res_ready) begin
          w_next = (r_discard | bus.flush) ? ST_IDLE : ST_RESP;
        end else if (w_timeout) begin
          w_next = ST_RESP;
        end
      end
      ST_RESP: begin
        // A multiplier that timed out cannot be trusted again, so even a
        // flushed error response parks the block until reset.
        if (bus.out_ready | bus.flush) begin
          w_next = r_hang ? ST_HUNG : ST_IDLE;
        end
      end
      ST_HUNG: begin
        w_next = ST_HUNG;
      end
      default: begin
        w_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_op      <= OP_MUL;
      r_rs1     <= '0;
      r_rs2     <= '0;
      r_tag     <= '0;
      r_usigned <= 1'b0;
      r_cnt     <= '0;
      r_discard <= 1'b0;
      r_hang    <= 1'b0;
      r_result  <= '0;
      r_err     <= 1'b0;
    end else begin
      if (w_accept) begin
        r_op      <= bus.in_op;
        r_rs1     <= bus.in_rs1;
        r_rs2     <= bus.in_rs2;
        r_tag     <= bus.in_tag;
        r_usigned <= op_usigned(bus.in_op);
        r_discard <= 1'b0;
        r_hang    <= 1'b0;
        if (w_illegal) begin
          r_result <= '0;
          r_err    <= 1'b1;
        end
      end

      if (r_state == ST_LAUNCH) begin
        r_cnt <= '0;
      end else if (r_state == ST_WAIT) begin
        r_cnt <= r_cnt + 1'b1;
      end

      if (((r_state == ST_LAUNCH) || (r_state == ST_WAIT)) && bus.flush) begin
        r_discard <= 1'b1;
      end

      if ((r_state == ST_WAIT) && (w_next == ST_RESP)) begin
        if (bus.mul_res_ready) begin
          r_result <= w_sel;
          r_err    <= 1'b0;
        end else begin
          r_result <= '0;
          r_err    <= 1'b1;
          r_hang   <= 1'b1;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mul_issue_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_mul_issue_seq
// Description : Self-checking bench for mul_issue_seq with a behavioural
//               multiplier of programmable latency. Table of directed
//               vectors plus hand sequences for backpressure, flush and
//               watchdog behaviour.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mul_issue_seq;
  import mdu_pkg::*;

  localparam int W        = 32;
  localparam int TAG_W    = 5;
  localparam int MAX_WAIT = 127;
  localparam int LIMIT    = 400;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mul_issue_seq_if #(.W(W), .TAG_W(TAG_W)) bus ();

  mul_issue_seq #(.W(W), .TAG_W(TAG_W), .MAX_WAIT(MAX_WAIT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] got,
                       input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", name, got, exp);
    end
  endtask

  // ---------------- behavioural multiplier ----------------
  int           mdl_cnt   = -1;
  int           mdl_lat   = 3;
  bit           mdl_dead  = 1'b0;
  int           mv_pulses = 0;
  logic [W-1:0] m_a, m_b;
  logic         m_u;

  function automatic logic [2*W-1:0] mdl_prod(input logic [W-1:0] a,
                                               input logic [W-1:0] b,
                                               input logic u);
    logic [2*W-1:0] ea, eb;
    ea = u ? {{W{1'b0}}, a} : {{W{a[W-1]}}, a};
    eb = u ? {{W{1'b0}}, b} : {{W{b[W-1]}}, b};
    return ea * eb;
  endfunction

  initial begin
    bus.mul_res_ready = 1'b0;
    bus.mul_product   = '0;
    forever begin
      @(negedge clk);
      bus.mul_res_ready = 1'b0;
      if (!rst_n) begin
        mdl_cnt = -1;
      end else if (mdl_cnt > 0) begin
        mdl_cnt--;
        if (mdl_cnt == 0) begin
          bus.mul_res_ready = 1'b1;
          bus.mul_product   = mdl_prod(m_a, m_b, m_u);
          mdl_cnt           = -1;
        end
      end
      if (rst_n && bus.mul_valid) begin
        mv_pulses++;
        if (!mdl_dead) begin
          m_a     = bus.mul_multiplicand;
          m_b     = bus.mul_multiplier;
          m_u     = bus.mul_usigned;
          mdl_cnt = mdl_lat;
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  logic l_mv, l_us, l_ir;

  task automatic send(input mdu_op_t op, input logic [W-1:0] a,
                      input logic [W-1:0] b, input logic [TAG_W-1:0] t);
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_op    = op;
    bus.in_rs1   = a;
    bus.in_rs2   = b;
    bus.in_tag   = t;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    l_mv = bus.mul_valid;
    l_us = bus.mul_usigned;
    l_ir = bus.in_ready;
  endtask

  // Called at the negedge of the cycle after accept; n = cycles from accept.
  task automatic wait_resp(output int n);
    n = 1;
    while (!bus.out_valid && n < LIMIT) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic consume();
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.out_ready = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    mdu_op_t          op;
    logic [W-1:0]     rs1;
    logic [W-1:0]     rs2;
    logic [TAG_W-1:0] tag;
    int               lat;
    logic [W-1:0]     exp_res;
    logic             exp_err;
    logic             exp_us;
    int               exp_latency;
    int               exp_pulses;
  } vec_t;

  localparam int NV = 10;
  vec_t vt[NV];

  function automatic vec_t mk(input mdu_op_t op, input logic [W-1:0] a,
                              input logic [W-1:0] b,
                              input logic [TAG_W-1:0] t, input int lat,
                              input logic [W-1:0] res, input logic us);
    vec_t v;
    v.op = op; v.rs1 = a; v.rs2 = b; v.tag = t; v.lat = lat;
    v.exp_res = res; v.exp_err = 1'b0; v.exp_us = us;
    v.exp_latency = lat + 2; v.exp_pulses = 1;
`ifndef MUL_ISSUE_MULHSU_EN
    if (op == OP_MULHSU) begin
      v.exp_res = '0; v.exp_err = 1'b1; v.exp_latency = 1; v.exp_pulses = 0;
    end
`endif
    return v;
  endfunction

  initial begin
    int n;
    bit seen;

    bus.in_valid  = 1'b0;
    bus.in_op     = OP_MUL;
    bus.in_rs1    = '0;
    bus.in_rs2    = '0;
    bus.in_tag    = '0;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b0;

    vt[0] = mk(OP_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'h15, 3,  32'hFFFF_FFFE, 1'b1);
    vt[1] = mk(OP_MUL,    32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'h02, 1,  32'h0000_0001, 1'b1);
    vt[2] = mk(OP_MULH,   32'hFFFF_FFFF, 32'h0000_0002, 5'h03, 5,  32'hFFFF_FFFF, 1'b0);
    vt[3] = mk(OP_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'h04, 4,  32'hFFFF_FFFF, 1'b1);
    vt[4] = mk(OP_MUL,    32'h0001_2345, 32'h0000_0010, 5'h05, 32, 32'h0012_3450, 1'b1);
    vt[5] = mk(OP_MULH,   32'h8000_0000, 32'h8000_0000, 5'h06, 2,  32'h4000_0000, 1'b0);
    vt[6] = mk(OP_MULHU,  32'h8000_0000, 32'h0000_0004, 5'h07, 6,  32'h0000_0002, 1'b1);
    vt[7] = mk(OP_MULHSU, 32'h7FFF_FFFF, 32'h0000_0002, 5'h08, 3,  32'h0000_0000, 1'b1);
    vt[8] = mk(OP_MULH,   32'h7FFF_FFFF, 32'h7FFF_FFFF, 5'h1F, 7,  32'h3FFF_FFFF, 1'b0);
    vt[9] = mk(OP_MULHU,  32'h0000_0000, 32'hDEAD_BEEF, 5'h00, 1,  32'h0000_0000, 1'b1);

    // ---------------- reset state ----------------
    do_reset();
    check("rst out_valid",   bus.out_valid,        0);
    check("rst mul_valid",   bus.mul_valid,        0);
    check("rst out_err",     bus.out_err,          0);
    check("rst out_result",  bus.out_result,       0);
    check("rst out_tag",     bus.out_tag,          0);
    check("rst operands",    {bus.mul_multiplicand, bus.mul_multiplier}, 0);
    check("rst mul_usigned", bus.mul_usigned,      0);
    check("rst in_ready",    bus.in_ready,         1);

    // flush has priority over in_valid in IDLE
    bus.flush    = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_op    = OP_MUL;
    #1;
    check("idle flush in_ready", bus.in_ready, 0);
    @(negedge clk);
    bus.flush    = 1'b0;
    bus.in_valid = 1'b0;
    #1;
    check("idle flush no launch", bus.mul_valid, 0);
    check("idle in_ready back",   bus.in_ready,  1);

    // ---------------- table-driven vectors ----------------
    for (int i = 0; i < NV; i++) begin
      mdl_lat   = vt[i].lat;
      mv_pulses = 0;
      send(vt[i].op, vt[i].rs1, vt[i].rs2, vt[i].tag);
      check($sformatf("v%0d in_ready after accept", i), l_ir, 0);
      if (vt[i].exp_pulses != 0) begin
        check($sformatf("v%0d launch mul_valid", i), l_mv, 1);
        check($sformatf("v%0d launch usigned", i),   l_us, vt[i].exp_us);
      end else begin
        check($sformatf("v%0d no launch", i), l_mv, 0);
      end
      wait_resp(n);
      check($sformatf("v%0d latency", i), n,              vt[i].exp_latency);
      check($sformatf("v%0d result", i),  bus.out_result, vt[i].exp_res);
      check($sformatf("v%0d tag", i),     bus.out_tag,    vt[i].tag);
      check($sformatf("v%0d err", i),     bus.out_err,    vt[i].exp_err);
      consume();
      check($sformatf("v%0d pulses", i),        mv_pulses,     vt[i].exp_pulses);
      check($sformatf("v%0d valid dropped", i), bus.out_valid, 0);
      check($sformatf("v%0d idle ready", i),    bus.in_ready,  1);
    end

    // ---------------- backpressure ----------------
    mdl_lat = 2;
    send(OP_MULHU, 32'h8000_0000, 32'h0000_0010, 5'h1A);
    wait_resp(n);
    check("bp latency", n, 4);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check($sformatf("bp hold %0d", k),
            {bus.out_valid, bus.in_ready, bus.out_result, bus.out_tag},
            {1'b1, 1'b0, 32'h0000_0008, 5'h1A});
    end
    consume();
    check("bp released", bus.out_valid, 0);

    // ---------------- flush in WAIT ----------------
    mdl_lat = 8;
    send(OP_MUL, 32'd3, 32'd5, 5'h07);
    @(negedge clk);
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    #1;
    check("wflush in_ready busy", bus.in_ready, 0);
    seen = 1'b0;
    for (int k = 1; k <= 15; k++) begin
      @(negedge clk);
      seen |= bus.out_valid;
      if (k == 6) check("wflush waits for done", bus.in_ready, 0);
    end
    check("wflush no response", seen,         0);
    check("wflush in_ready",    bus.in_ready, 1);

    // ---------------- flush in RESP ----------------
    mdl_lat = 1;
    send(OP_MULHU, 32'hFFFF_FFFF, 32'h0000_0002, 5'h03);
    wait_resp(n);
    check("rflush result", bus.out_result, 32'h0000_0001);
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    #1;
    check("rflush valid dropped", bus.out_valid, 0);
    check("rflush in_ready",      bus.in_ready,  1);

    // ---------------- watchdog ----------------
    mdl_dead  = 1'b1;
    mv_pulses = 0;
    send(OP_MUL, 32'd9, 32'd9, 5'h11);
    wait_resp(n);
    check("wd latency", n,              MAX_WAIT + 2);
    check("wd err",     bus.out_err,    1);
    check("wd result",  bus.out_result, 0);
    check("wd tag",     bus.out_tag,    5'h11);
    consume();
    check("wd pulses", mv_pulses, 1);
    bus.in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check($sformatf("hung %0d", k),
            {bus.in_ready, bus.out_valid, bus.mul_valid}, 3'b000);
    end
    bus.in_valid = 1'b0;
    mdl_dead = 1'b0;
    do_reset();
    check("post-reset in_ready", bus.in_ready, 1);
    check("post-reset out_err",  bus.out_err,  0);

    // recovery after reset
    mdl_lat = 2;
    send(OP_MUL, 32'd6, 32'd7, 5'h09);
    wait_resp(n);
    check("recover latency", n,              4);
    check("recover result",  bus.out_result, 32'd42);
    consume();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
